// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - registered, handshaked arbiter sharing memory port A between mic1 and the external host
module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_CPU_BURST = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              host_lock,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_stall
);

  // Owner of the read whose data arrives on mem_rdata this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_EXT  = 2'd2
  } owner_e;

  localparam logic [3:0] BURST_MAX = 4'(MAX_CPU_BURST);

  owner_e            owner_q, owner_d;
  logic [3:0]        burst_cnt_q, burst_cnt_d;
  logic              cpu_stall_q, cpu_stall_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;
  logic              ext_wins;

  // Arbitration: ext wins under lock, when the CPU is idle, or when the CPU has used up its burst.
  always_comb begin
    ext_wins = 1'b0;
    cpu_gnt  = 1'b0;
    ext_gnt  = 1'b0;
    if (resetn) begin
      ext_wins = ext_req && (host_lock || !cpu_req || (burst_cnt_q == BURST_MAX));
      cpu_gnt  = cpu_req && !host_lock && !ext_wins;
      ext_gnt  = ext_wins;
    end
  end

  // Drive port A from the winner; idle port is held at all-zero.
  always_comb begin
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_wen   = cpu_we;
      mem_ren   = !cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (ext_gnt) begin
      mem_wen   = ext_we;
      mem_ren   = !ext_we;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end
  end

  // Read return: the registered owner sees mem_rdata for one cycle; the other side keeps its last data.
  always_comb begin
    cpu_rvalid  = (owner_q == OWN_CPU);
    ext_rvalid  = (owner_q == OWN_EXT);
    cpu_rdata   = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    ext_rdata   = ext_rvalid ? mem_rdata : ext_rdata_q;
    cpu_rdata_d = cpu_rdata;
    ext_rdata_d = ext_rdata;
    cpu_stall   = cpu_stall_q;
  end

  // Next state: read owner, CPU burst count while ext waits, and the one-cycle-late stall.
  always_comb begin
    owner_d     = OWN_NONE;
    burst_cnt_d = burst_cnt_q;
    cpu_stall_d = host_lock || (cpu_req && !cpu_gnt);
    if (cpu_gnt && !cpu_we) begin
      owner_d = OWN_CPU;
    end else if (ext_gnt && !ext_we) begin
      owner_d = OWN_EXT;
    end
    if (ext_gnt || !ext_req) begin
      burst_cnt_d = '0;
    end else if (cpu_gnt && (burst_cnt_q < BURST_MAX)) begin
      burst_cnt_d = burst_cnt_q + 4'd1;
    end
  end

  // State registers; reset drops any in-flight read and asserts the stall.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_q     <= OWN_NONE;
      burst_cnt_q <= '0;
      cpu_stall_q <= 1'b1;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      cpu_stall_q <= cpu_stall_d;
      cpu_rdata_q <= cpu_rdata_d;
      ext_rdata_q <= ext_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXB = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          host_lock;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          ext_req, ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_gnt, ext_rvalid;
  logic [DW-1:0] ext_rdata;
  logic          mem_wen, mem_ren;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          cpu_stall;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_CPU_BURST(MAXB)) dut (
    .clk(clk), .resetn(resetn), .host_lock(host_lock),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cpu_stall(cpu_stall)
  );

  always #5 clk = ~clk;

  // Port A memory: synchronous, one cycle read latency.
  logic [DW-1:0] env_mem [0:255];
  always @(posedge clk) begin
    if (mem_wen) env_mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_ren) mem_rdata <= env_mem[mem_addr[7:0]];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: arbitration rules, pending read queue and a shadow memory.
  logic [DW-1:0] model_mem [0:255];
  int            m_wait;
  logic          m_stall;
  int            m_pend;
  logic [DW-1:0] m_pend_data, m_cpu_rd, m_ext_rd;
  logic          e_cg, e_eg, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd;

  // Compare every cycle at the falling edge, then advance the model to the next cycle.
  always @(negedge clk) begin
    if (!resetn) begin
      chk("rst_cpu_gnt", {31'b0, cpu_gnt}, 0);
      chk("rst_ext_gnt", {31'b0, ext_gnt}, 0);
      chk("rst_cpu_rvalid", {31'b0, cpu_rvalid}, 0);
      chk("rst_ext_rvalid", {31'b0, ext_rvalid}, 0);
      chk("rst_mem_wen", {31'b0, mem_wen}, 0);
      chk("rst_mem_ren", {31'b0, mem_ren}, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_ext_rdata", ext_rdata, 0);
      chk("rst_cpu_stall", {31'b0, cpu_stall}, 1);
      m_wait = 0; m_stall = 1'b1; m_pend = 0; m_cpu_rd = '0; m_ext_rd = '0;
    end else begin
      e_cg = !host_lock && cpu_req && !(ext_req && m_wait >= MAXB);
      e_eg = ext_req && !e_cg;
      e_we = e_cg ? cpu_we : ext_we;
      e_addr = e_cg ? cpu_addr : (e_eg ? ext_addr : '0);
      e_wd = e_cg ? cpu_wdata : (e_eg ? ext_wdata : '0);
      chk("m_cpu_gnt", {31'b0, cpu_gnt}, {31'b0, e_cg});
      chk("m_ext_gnt", {31'b0, ext_gnt}, {31'b0, e_eg});
      chk("m_mem_wen", {31'b0, mem_wen}, {31'b0, (e_cg || e_eg) && e_we});
      chk("m_mem_ren", {31'b0, mem_ren}, {31'b0, (e_cg || e_eg) && !e_we});
      chk("m_mem_addr", mem_addr, e_addr);
      chk("m_mem_wdata", mem_wdata, e_wd);
      chk("m_cpu_rvalid", {31'b0, cpu_rvalid}, {31'b0, m_pend == 1});
      chk("m_ext_rvalid", {31'b0, ext_rvalid}, {31'b0, m_pend == 2});
      chk("m_cpu_rdata", cpu_rdata, (m_pend == 1) ? m_pend_data : m_cpu_rd);
      chk("m_ext_rdata", ext_rdata, (m_pend == 2) ? m_pend_data : m_ext_rd);
      chk("m_cpu_stall", {31'b0, cpu_stall}, {31'b0, m_stall});
      if (m_pend == 1) m_cpu_rd = m_pend_data;
      if (m_pend == 2) m_ext_rd = m_pend_data;
      m_stall = host_lock || (cpu_req && !e_cg);
      if (e_eg || !ext_req) m_wait = 0;
      else if (e_cg && m_wait < MAXB) m_wait++;
      m_pend = 0;
      if (e_cg || e_eg) begin
        if (e_we) model_mem[e_addr[7:0]] = e_wd;
        else begin
          m_pend = e_cg ? 1 : 2;
          m_pend_data = model_mem[e_addr[7:0]];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  string pat;
  logic  st [0:9];
  int    n_eg, n_cg, n_st;

  initial begin
    resetn = 1'b0; host_lock = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      env_mem[i]   = 32'hA500_0000 + i;
      model_mem[i] = 32'hA500_0000 + i;
    end
    env_mem[8'h10] = 32'd7; model_mem[8'h10] = 32'd7;
    env_mem[8'h11] = 32'd9; model_mem[8'h11] = 32'd9;

    // Reset, release, then reset again while an ext read is in flight.
    at_neg();
    chk("t1_stall_in_reset", {31'b0, cpu_stall}, 1);
    tick(); resetn = 1'b1;
    tick(); tick();
    at_neg();
    chk("t1_stall_released", {31'b0, cpu_stall}, 0);
    tick(); ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h10;
    at_neg();
    chk("t1_ext_gnt", {31'b0, ext_gnt}, 1);
    tick(); ext_req = 1'b0; resetn = 1'b0;
    at_neg();
    chk("t1_no_rvalid", {31'b0, ext_rvalid}, 0);
    chk("t1_stall_rst", {31'b0, cpu_stall}, 1);
    tick(); resetn = 1'b1;
    tick(); tick();

    // Solo CPU write then read of 0x50.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h50; cpu_wdata = 32'hDEADBEEF;
    at_neg();
    chk("t2_wen", {31'b0, mem_wen}, 1);
    chk("t2_addr", mem_addr, 32'h50);
    chk("t2_wdata", mem_wdata, 32'hDEADBEEF);
    tick(); cpu_we = 1'b0;
    at_neg();
    chk("t2_ren", {31'b0, mem_ren}, 1);
    tick(); cpu_req = 1'b0;
    at_neg();
    chk("t2_rvalid", {31'b0, cpu_rvalid}, 1);
    chk("t2_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("t2_ext_rvalid", {31'b0, ext_rvalid}, 0);

    // Pipelined mix: ext read 0x10 then CPU read 0x11.
    tick(); ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h10;
    at_neg();
    chk("t6_ext_gnt", {31'b0, ext_gnt}, 1);
    tick(); ext_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h11;
    at_neg();
    chk("t6_ext_rvalid", {31'b0, ext_rvalid}, 1);
    chk("t6_ext_rdata", ext_rdata, 32'd7);
    chk("t6_cpu_gnt", {31'b0, cpu_gnt}, 1);
    tick(); cpu_req = 1'b0;
    at_neg();
    chk("t6_cpu_rvalid", {31'b0, cpu_rvalid}, 1);
    chk("t6_cpu_rdata", cpu_rdata, 32'd9);
    chk("t6_ext_quiet", {31'b0, ext_rvalid}, 0);
    chk("t6_ext_hold", ext_rdata, 32'd7);

    // Read ownership across host_lock assertion.
    tick(); cpu_req = 1'b1; cpu_addr = 32'h11;
    at_neg();
    chk("t5_cpu_gnt", {31'b0, cpu_gnt}, 1);
    tick(); cpu_req = 1'b0; host_lock = 1'b1;
    at_neg();
    chk("t5_cpu_rvalid", {31'b0, cpu_rvalid}, 1);
    chk("t5_cpu_rdata", cpu_rdata, 32'd9);
    chk("t5_ext_rvalid", {31'b0, ext_rvalid}, 0);
    tick(); host_lock = 1'b0;
    tick();

    // Contention with both requests held.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h21;
    pat = "";
    for (int k = 0; k < 10; k++) begin
      at_neg();
      pat = {pat, cpu_gnt ? "C" : (ext_gnt ? "E" : "-")};
      st[k] = cpu_stall;
      tick();
    end
    cpu_req = 1'b0; ext_req = 1'b0;
    checks++;
    if (pat != "CCCCECCCCE") begin
      errors++;
      $display("FAIL t3_pattern: got %s expected CCCCECCCCE", pat);
    end
    chk("t3_stall_c4", {31'b0, st[4]}, 0);
    chk("t3_stall_after_e", {31'b0, st[5]}, 1);
    tick();

    // Host lock: 131 ext writes while the CPU keeps requesting.
    host_lock = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30;
    ext_req = 1'b1; ext_we = 1'b1;
    n_eg = 0; n_cg = 0; n_st = 0;
    for (int i = 0; i <= 8'h82; i++) begin
      ext_addr = i; ext_wdata = 32'h100 + i;
      at_neg();
      if (ext_gnt) n_eg++;
      if (cpu_gnt) n_cg++;
      if (i > 0 && cpu_stall) n_st++;
      tick();
    end
    host_lock = 1'b0; ext_req = 1'b0;
    chk("t4_ext_gnts", n_eg, 131);
    chk("t4_cpu_gnts", n_cg, 0);
    chk("t4_stall_cycles", n_st, 130);
    at_neg();
    chk("t4_cpu_after_lock", {31'b0, cpu_gnt}, 1);
    tick(); cpu_req = 1'b0;

    // Read-after-write in consecutive cycles.
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h40; ext_wdata = 32'h1234;
    at_neg();
    chk("raw_ext_gnt", {31'b0, ext_gnt}, 1);
    tick(); ext_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    tick(); cpu_req = 1'b0;
    at_neg();
    chk("raw_rdata", cpu_rdata, 32'h1234);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
